fetch_sequencer: RTL
====================

# fetch_sequencer

Next-PC and instruction-fetch controller for the RV32I core. It computes the value loaded into the program counter register every cycle and issues instruction-memory requests at the current PC. It holds one fetched instruction for decode and handles branch/jump redirects, pipeline stalls, misaligned-target traps and a debug halt/resume. It sits between the program counter register, instruction memory and the decode stage.

## Interface
- RESET_PC, 32'h00010000, boot address; the program counter register resets to the same value.
- TRAP_VEC, 32'h00000100, PC loaded on a misaligned redirect target.
- clk  in  1  clock; all state updates on the posedge.
- rst  in  1  synchronous, active-high reset.
- pc_cur  in  32  current PC from the program counter register output.
- pc_next  out  32  next PC to the program counter register input; combinational.
- imem_req  out  1  fetch request; combinational.
- imem_addr  out  32  fetch address; always equals pc_cur.
- imem_ack  in  1  memory returns imem_rdata this cycle; may be asserted in the same cycle as imem_req.
- imem_rdata  in  32  fetched instruction word.
- inst_valid  out  1  buffered instruction available to decode; registered.
- inst  out  32  buffered instruction; registered.
- inst_pc  out  32  address of inst; registered.
- inst_ready  in  1  decode accepts inst this cycle.
- stall  in  1  hazard stall: no new request, PC held.
- redirect_valid  in  1  branch/jump taken; one-cycle pulse from execute.
- redirect_target  in  32  redirect address.
- halt_req  in  1  debug halt request; level.
- resume  in  1  debug resume; pulse.
- trap  out  1  one-cycle pulse on a misaligned redirect; registered.
- halted  out  1  core is halted; registered.

## Operation
- States: BOOT, RUN, HALT_PEND, HALTED.
- Reset (rst=1): state=BOOT, inst_valid=0, inst=0, inst_pc=0, trap=0, halted=0, pc_next=RESET_PC, imem_req=0.
- **BOOT:** lasts one cycle with no request, pc_next=RESET_PC. Then goes to RUN, or to HALT_PEND if halt_req=1.
- **Request rule:** imem_req = state==RUN and !stall and !redirect_valid and (!inst_valid or inst_ready).
- **Fetch accept:** imem_req and imem_ack. Then pc_next=pc_cur+4 (mod 2^32, wraps 0xFFFFFFFC→0), inst←imem_rdata, inst_pc←pc_cur, inst_valid←1.
- **Consume only:** inst_valid and inst_ready without a fetch accept. Then inst_valid←0.
- **Otherwise:** pc_next=pc_cur (hold), including a pending request without ack. The requester keeps imem_req/imem_addr stable until ack unless a redirect, stall or halt drops it. Memory must tolerate abandoned requests and ignore any late data.
- **Redirect (RUN or HALT_PEND):** takes highest priority over fetch, consume and stall.
  - inst_valid←0, which flushes the buffer even if inst_ready=1.
  - If redirect_target[1:0]==0: pc_next=redirect_target.
  - Else: pc_next=TRAP_VEC and trap←1 for the next cycle.
  - A redirect from HALT_PEND goes to HALTED.
- **Redirect in BOOT or HALTED:** ignored.
- **halt_req=1 in RUN:** go to HALT_PEND; no new requests from this cycle.
- **HALT_PEND:** inst_valid may still drain via inst_ready. Go to HALTED in the cycle after inst_valid is 0. pc_next=pc_cur unless redirected.
- **HALTED:** halted=1, imem_req=0, pc_next=pc_cur. resume=1 → RUN, and halted clears the next cycle. resume is ignored in other states.
- stall does not affect the state; it only suppresses imem_req.

## Timing
- One-cycle PC loop: pc_next is sampled by the program counter register, and pc_cur reflects it at the next posedge.
- First request: the cycle after BOOT, at address RESET_PC.
- Fetch latency: ack at cycle N → inst_valid=1 and inst valid at N+1.
- Peak throughput: one instruction per cycle with a same-cycle ack and inst_ready held high.
- Redirect: pulse at cycle N → request at the new target at N+1, with inst_valid=0 at N+1.
- trap is high exactly at N+1 for a misaligned redirect at N.
- Halt: halted rises 1 cycle after the buffer is empty. Resume at N → halted=0 and a request at N+1.
- rst mid-operation aborts everything: no request in the rst cycle, reset values on the next cycle.

## Test plan
- **Boot fetch:** rst for 2 cycles then release, imem_ack tied 1, inst_ready=1 → imem_addr 0x10000, 0x10004, 0x10008 on consecutive cycles; inst_pc follows one cycle later.
- **Backpressure:** inst_ready=0 after the first fetch → imem_req=0, PC held at 0x10004, inst stable. Raise inst_ready → fetch of 0x10004 in the same cycle.
- **Redirect:** redirect to 0x10200 while inst_valid=1 and an ack is pending → inst_valid=0 next cycle, next request at 0x10200, late ack data never appears on inst.
- **Misaligned redirect:** target 0x10202 → trap pulse for 1 cycle, next request at 0x100, buffer flushed.
- **Halt/resume with stall:** halt_req with a full buffer and stall=1 → no requests; after inst_ready drains, halted=1 one cycle later, PC frozen. resume → request at the same PC next cycle.
- **Wrap:** with pc_cur=0xFFFFFFFC and an ack → pc_next=0x00000000.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer_if
// Description : PC loop, instruction-memory and decode-side signals of the
//               fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic        trap;
    logic        halted;

    // The sequencer drives the master side.
    modport master (
        input  pc_cur, imem_ack, imem_rdata, inst_ready, stall,
               redirect_valid, redirect_target, halt_req, resume,
        output pc_next, imem_req, imem_addr, inst_valid, inst, inst_pc,
               trap, halted
    );

    modport slave (
        output pc_cur, imem_ack, imem_rdata, inst_ready, stall,
               redirect_valid, redirect_target, halt_req, resume,
        input  pc_next, imem_req, imem_addr, inst_valid, inst, inst_pc,
               trap, halted
    );
endinterface
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Next-PC and instruction-fetch controller with a one-entry
//               decode buffer, redirects, misaligned traps and debug halt.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0001_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fetch_sequencer_if.master  fetch
);

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_RUN       = 2'd1,
        ST_HALT_PEND = 2'd2,
        ST_HALTED    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_trap;
    logic        r_halted;

    logic        w_req;
    logic        w_accept;
    logic        w_redir;
    logic        w_misaligned;
    logic [31:0] w_pc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_redir      = 1'b0;
        w_accept     = 1'b0;
        w_pc_next    = fetch.pc_cur;
        w_misaligned = (fetch.redirect_target[1:0] != 2'b00);

        case (r_state)
            ST_BOOT: begin
                w_pc_next    = RESET_PC;
                w_state_next = fetch.halt_req ? ST_HALT_PEND : ST_RUN;
            end
            ST_RUN: begin
                w_redir = fetch.redirect_valid;
                w_req   = !fetch.stall && !fetch.redirect_valid && !fetch.halt_req &&
                          (!r_inst_valid || fetch.inst_ready);
                if (fetch.halt_req) begin
                    w_state_next = ST_HALT_PEND;
                end
            end
            ST_HALT_PEND: begin
                w_redir = fetch.redirect_valid;
                // Buffer already empty (or flushed by a redirect): halt next cycle.
                if (fetch.redirect_valid || !r_inst_valid) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (fetch.resume) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase

        w_accept = w_req && fetch.imem_ack;

        if (w_redir) begin
            w_pc_next = w_misaligned ? TRAP_VEC : fetch.redirect_target;
        end else if (w_accept) begin
            w_pc_next = fetch.pc_cur + 32'd4;
        end

        // Reset aborts everything, including the combinational request.
        if (rst) begin
            w_state_next = ST_BOOT;
            w_req        = 1'b0;
            w_accept     = 1'b0;
            w_redir      = 1'b0;
            w_pc_next    = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_valid <= 1'b0;
            r_inst       <= 32'd0;
            r_inst_pc    <= 32'd0;
            r_trap       <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_trap   <= w_redir && w_misaligned;
            r_halted <= (w_state_next == ST_HALTED);
            if (w_redir) begin
                r_inst_valid <= 1'b0;
            end else if (w_accept) begin
                r_inst_valid <= 1'b1;
                r_inst       <= fetch.imem_rdata;
                r_inst_pc    <= fetch.pc_cur;
            end else if (r_inst_valid && fetch.inst_ready) begin
                r_inst_valid <= 1'b0;
            end
        end
    end

    assign fetch.pc_next    = w_pc_next;
    assign fetch.imem_req   = w_req;
    assign fetch.imem_addr  = fetch.pc_cur;
    assign fetch.inst_valid = r_inst_valid;
    assign fetch.inst       = r_inst;
    assign fetch.inst_pc    = r_inst_pc;
    assign fetch.trap       = r_trap;
    assign fetch.halted     = r_halted;

endmodule
`default_nettype wire
